vram_write_sched: RTL and testbench
===================================

# vram_write_sched

Write-port scheduler for the 256x256 RGB VRAM behind the 800x600 VGA display controller. It shares the single VRAM write port (8-bit x/y address, 8-bit R/G/B data) between a host pixel-write stream and an internal rectangle-fill engine. It drives registered write address, data and enable toward the VRAM. The fill engine clears or paints an axis-aligned rectangle in raster order from one start command.

## Interface
- No parameters; widths are fixed by the 256x256x24 VRAM.
- iCLK  in  1  pixel clock (40 MHz), all logic on rising edge
- iRST_N  in  1  synchronous reset, active low
- host_valid  in  1  host pixel write request
- host_ready  out  1  host beat accepted this cycle (combinational grant)
- host_x, host_y  in  8 each  host pixel coordinate
- host_r, host_g, host_b  in  8 each  host pixel colour
- fill_start  in  1  one-cycle start pulse; sampled only in IDLE
- fill_abort  in  1  terminate fill without fill_done
- fill_x0, fill_y0, fill_x1, fill_y1  in  8 each  opposite corners, inclusive
- fill_r, fill_g, fill_b  in  8 each  fill colour
- fill_busy  out  1  fill engine in RUN
- fill_done  out  1  one-cycle pulse with the last fill write
- write_x, write_y  out  8 each  VRAM write address (registered)
- write_r, write_g, write_b  out  8 each  VRAM write data (registered)
- write_en  out  1  VRAM write strobe (registered)

## Operation
- Reset: write_x/y/r/g/b = 0, write_en = 0, fill_busy = 0, fill_done = 0, FSM = IDLE, priority pointer = host.
- Fill FSM has two states, IDLE and RUN.
  - IDLE to RUN on fill_start & !fill_abort.
  - On that transition, capture xmin = min(x0,x1), xmax = max(x0,x1), ymin and ymax likewise, and the colour.
  - Set cursor (cx,cy) = (xmin,ymin).
  - fill_start in RUN is ignored. fill_start and fill_abort together in IDLE: abort wins, start ignored.
- RUN requests the port every cycle. On each fill grant, write (cx,cy) with the fill colour, then advance the cursor:
  - if cx < xmax: cx+1;
  - else cx = xmin and cy+1.
  - Grant with cx == xmax and cy == ymax is last: go to IDLE and set fill_done for the next cycle.
  - The cursor is compared before increment, so xmax/ymax = 255 never wraps.
- fill_abort in RUN suppresses that cycle's fill grant, goes to IDLE, and produces no fill_done. Pixels already written stay.
- Arbitration each cycle:
  - requesters are host (host_valid) and fill (state RUN and no abort);
  - a single requester wins;
  - if both request, the pointer side wins;
  - after any grant, the pointer moves to the other side. Result: strict alternation under contention.
- host_ready = host grant. It is combinational from host_valid, state, abort and pointer, and never depends on host_ready itself.
- A host beat transfers when host_valid & host_ready. Host data must stay stable while valid and not ready.
- Write register update:
  - on a grant, load the winner's address and data and set write_en = 1;
  - with no grant, write_en = 0 and address/data HOLD their last values, so a permanently enabled VRAM only rewrites the same pixel with the same data.
- Pixel count per fill = (xmax-xmin+1)*(ymax-ymin+1), 1..65536.

## Timing
- Latency: grant at edge N means write_en, address and data are valid in the cycle after edge N.
- Start sampled at edge S. First fill grant at edge S+1 at the earliest, and the first write_en is visible after S+1.
- Uncontended fill throughput is 1 pixel/cycle; a WxH fill is fully written after S+W*H.
- Contended throughput is 1 pixel per 2 cycles per requester.
- fill_busy goes high after edge S and low after the last-grant edge L.
- fill_done is high for exactly the one cycle after L, coincident with the last write_en.
- The host can be granted in the cycle L+1 with no bubble.
- Reset asserted mid-fill at any edge returns everything to reset values at that edge. No fill_done is produced, and any pending host beat is not accepted.

## Test plan
- Reset: hold iRST_N=0 three cycles with host_valid=1 and fill_start=1 -> all outputs 0, host_ready=0, fill_busy=0.
- 2x2 fill: start with (10,20)-(11,21), colour (FF,00,80), host idle.
  - Expected: writes (10,20),(11,20),(10,21),(11,21) on 4 consecutive cycles.
  - fill_done coincides with (11,21); fill_busy is high 4 cycles.
- Reversed corners: (5,5)-(3,4) -> writes (3,4),(4,4),(5,4),(3,5),(4,5),(5,5), 6 writes total, then done.
- Contention: host_valid held high, streaming (100+k,7), during a 1x4 fill at (0,0)-(3,0).
  - Expected: write_en stream alternates host,fill,host,fill,... starting with host.
  - All 4 fill pixels are written and fill_done comes with the 4th.
  - Host beats only advance when host_ready=1.
- Abort: 4x4 fill, pulse fill_abort after 5 fill writes -> no further fill writes, fill_done never asserts, fill_busy low next cycle. A fill_start in the same cycle as the abort is ignored.
- Full screen: (0,0)-(255,255) with no host.
  - Expected: 65536 consecutive writes with no cursor wrap.
  - The last write is (255,255) with fill_done, then write_en=0 and write_x/y hold at 255.

Source files
------------

// File: rtl/vram_write_sched.sv
// vram_write_sched
//   Shares the single 256x256x24 VRAM write port between a host pixel-write
//   stream and an internal rectangle-fill engine. The fill engine walks an
//   axis-aligned rectangle in raster order from one start command. Host and
//   fill contend through a round-robin pointer, so contention gives strict
//   alternation.
//
// Ports
//   iCLK, iRST_N             clock, synchronous active-low reset
//   host_valid/host_ready    host handshake (ready is the combinational grant)
//   host_x/y/r/g/b           host pixel coordinate and colour
//   fill_start, fill_abort   fill command pulse and terminate request
//   fill_x0/y0/x1/y1         opposite rectangle corners, inclusive
//   fill_r/g/b               fill colour
//   fill_busy, fill_done     engine running, one-cycle pulse with last write
//   write_x/y/r/g/b, write_en registered VRAM write port
module vram_write_sched (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       host_valid,
  output logic       host_ready,
  input  logic [7:0] host_x,
  input  logic [7:0] host_y,
  input  logic [7:0] host_r,
  input  logic [7:0] host_g,
  input  logic [7:0] host_b,
  input  logic       fill_start,
  input  logic       fill_abort,
  input  logic [7:0] fill_x0,
  input  logic [7:0] fill_y0,
  input  logic [7:0] fill_x1,
  input  logic [7:0] fill_y1,
  input  logic [7:0] fill_r,
  input  logic [7:0] fill_g,
  input  logic [7:0] fill_b,
  output logic       fill_busy,
  output logic       fill_done,
  output logic [7:0] write_x,
  output logic [7:0] write_y,
  output logic [7:0] write_r,
  output logic [7:0] write_g,
  output logic [7:0] write_b,
  output logic       write_en
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Priority pointer encoding: 0 favours host, 1 favours fill.
  localparam logic PTR_HOST = 1'b0;
  localparam logic PTR_FILL = 1'b1;

  logic [0:0] state;
  logic       ptr;

  logic [7:0] xmin, xmax, ymin, ymax;
  logic [7:0] cx, cy;
  logic [7:0] col_r, col_g, col_b;

  logic fill_req;
  logic grant_host;
  logic grant_fill;
  logic last_px;
  logic start_ok;

  // Grants are masked while reset is asserted so no host beat is accepted
  // during reset.
  assign fill_req   = (state == ST_RUN) && !fill_abort;
  assign grant_host = iRST_N && host_valid && (!fill_req || ptr == PTR_HOST);
  assign grant_fill = iRST_N && fill_req && (!host_valid || ptr == PTR_FILL);
  assign host_ready = grant_host;

  // Comparing the cursor before incrementing keeps xmax/ymax = 255 from wrapping.
  assign last_px  = (cx == xmax) && (cy == ymax);
  assign start_ok = (state == ST_IDLE) && fill_start && !fill_abort;

  assign fill_busy = (state == ST_RUN);

  // Control, arbitration pointer and registered write port.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state     <= ST_IDLE;
      ptr       <= PTR_HOST;
      fill_done <= 1'b0;
      write_en  <= 1'b0;
      write_x   <= 8'd0;
      write_y   <= 8'd0;
      write_r   <= 8'd0;
      write_g   <= 8'd0;
      write_b   <= 8'd0;
    end else begin
      fill_done <= 1'b0;
      write_en  <= grant_host || grant_fill;

      // Without a grant the address/data hold, so an always-enabled VRAM
      // just rewrites the same pixel with the same colour.
      if (grant_host) begin
        write_x <= host_x;
        write_y <= host_y;
        write_r <= host_r;
        write_g <= host_g;
        write_b <= host_b;
        ptr     <= PTR_FILL;
      end else if (grant_fill) begin
        write_x <= cx;
        write_y <= cy;
        write_r <= col_r;
        write_g <= col_g;
        write_b <= col_b;
        ptr     <= PTR_HOST;
      end

      case (state)
        ST_IDLE: begin
          if (start_ok) state <= ST_RUN;
        end
        ST_RUN: begin
          if (fill_abort) begin
            state <= ST_IDLE;
          end else if (grant_fill && last_px) begin
            state     <= ST_IDLE;
            fill_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Rectangle bounds, colour and raster cursor; pure data, no reset needed.
  always_ff @(posedge iCLK) begin
    if (start_ok) begin
      xmin  <= (fill_x0 < fill_x1) ? fill_x0 : fill_x1;
      xmax  <= (fill_x0 < fill_x1) ? fill_x1 : fill_x0;
      ymin  <= (fill_y0 < fill_y1) ? fill_y0 : fill_y1;
      ymax  <= (fill_y0 < fill_y1) ? fill_y1 : fill_y0;
      cx    <= (fill_x0 < fill_x1) ? fill_x0 : fill_x1;
      cy    <= (fill_y0 < fill_y1) ? fill_y0 : fill_y1;
      col_r <= fill_r;
      col_g <= fill_g;
      col_b <= fill_b;
    end else if (grant_fill && !last_px) begin
      if (cx < xmax) begin
        cx <= cx + 8'd1;
      end else begin
        cx <= xmin;
        cy <= cy + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vram_write_sched.sv
// tb_vram_write_sched
//   Directed bench for vram_write_sched: reset, small fills, reversed
//   corners, host/fill contention, abort, reset mid-fill and a full-screen
//   fill. Expected values are computed from the rectangle geometry.
module tb_vram_write_sched;

  logic       iCLK = 1'b0;
  logic       iRST_N;
  logic       host_valid;
  logic       host_ready;
  logic [7:0] host_x, host_y, host_r, host_g, host_b;
  logic       fill_start, fill_abort;
  logic [7:0] fill_x0, fill_y0, fill_x1, fill_y1;
  logic [7:0] fill_r, fill_g, fill_b;
  logic       fill_busy, fill_done;
  logic [7:0] write_x, write_y, write_r, write_g, write_b;
  logic       write_en;

  int checks = 0;
  int errors = 0;

  vram_write_sched dut (
    .iCLK       (iCLK),
    .iRST_N     (iRST_N),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_x     (host_x),
    .host_y     (host_y),
    .host_r     (host_r),
    .host_g     (host_g),
    .host_b     (host_b),
    .fill_start (fill_start),
    .fill_abort (fill_abort),
    .fill_x0    (fill_x0),
    .fill_y0    (fill_y0),
    .fill_x1    (fill_x1),
    .fill_y1    (fill_y1),
    .fill_r     (fill_r),
    .fill_g     (fill_g),
    .fill_b     (fill_b),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .write_x    (write_x),
    .write_y    (write_y),
    .write_r    (write_r),
    .write_g    (write_g),
    .write_b    (write_b),
    .write_en   (write_en)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  function automatic logic [63:0] wr_state();
    return {21'd0, write_en, write_x, write_y, write_r, write_g, write_b, fill_done, fill_busy};
  endfunction

  function automatic logic [63:0] wr_exp(input logic en, input logic [7:0] x, input logic [7:0] y,
                                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                         input logic done, input logic busy);
    return {21'd0, en, x, y, r, g, b, done, busy};
  endfunction

  // Runs one uncontended fill and checks every write; large fills are
  // tallied and reported as one comparison.
  task automatic run_fill(input string tag, input logic [7:0] x0, input logic [7:0] y0,
                          input logic [7:0] x1, input logic [7:0] y1,
                          input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int xa, xb, ya, yb, n, bad;
    logic last;
    xa = (x0 < x1) ? int'(x0) : int'(x1);
    xb = (x0 < x1) ? int'(x1) : int'(x0);
    ya = (y0 < y1) ? int'(y0) : int'(y1);
    yb = (y0 < y1) ? int'(y1) : int'(y0);
    n = (xb - xa + 1) * (yb - ya + 1);
    bad = 0;
    fill_x0 = x0; fill_y0 = y0; fill_x1 = x1; fill_y1 = y1;
    fill_r = r; fill_g = g; fill_b = b;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    check({tag, "_start"}, {62'd0, write_en, fill_busy}, 64'd1);
    for (int y = ya; y <= yb; y++) begin
      for (int x = xa; x <= xb; x++) begin
        tick();
        last = (x == xb) && (y == yb);
        if (n <= 64)
          check($sformatf("%s_px_%0d_%0d", tag, x, y), wr_state(),
                wr_exp(1'b1, 8'(x), 8'(y), r, g, b, last, !last));
        else if (wr_state() !== wr_exp(1'b1, 8'(x), 8'(y), r, g, b, last, !last))
          bad++;
      end
    end
    if (n > 64) check({tag, "_bad_px"}, 64'(bad), 64'd0);
    tick();
    check({tag, "_after"}, wr_state(), wr_exp(1'b0, 8'(xb), 8'(yb), r, g, b, 1'b0, 1'b0));
  endtask

  initial begin
    int k;
    logic hr;

    // Reset held with requests active.
    iRST_N = 1'b0; host_valid = 1'b1; fill_start = 1'b1; fill_abort = 1'b0;
    host_x = 8'd1; host_y = 8'd2; host_r = 8'd3; host_g = 8'd4; host_b = 8'd5;
    fill_x0 = 8'd0; fill_y0 = 8'd0; fill_x1 = 8'd1; fill_y1 = 8'd1;
    fill_r = 8'd9; fill_g = 8'd9; fill_b = 8'd9;
    repeat (3) tick();
    check("rst_outputs", wr_state(), 64'd0);
    check("rst_host_ready", 64'(host_ready), 64'd0);
    iRST_N = 1'b1; host_valid = 1'b0; fill_start = 1'b0;
    tick();
    check("idle_after_rst", wr_state(), 64'd0);

    run_fill("fill2x2", 8'd10, 8'd20, 8'd11, 8'd21, 8'hFF, 8'h00, 8'h80);
    run_fill("rev", 8'd5, 8'd5, 8'd3, 8'd4, 8'h12, 8'h34, 8'h56);

    // Abort after five writes of a 4x4 fill, with a coincident start.
    fill_x0 = 8'd0; fill_y0 = 8'd0; fill_x1 = 8'd3; fill_y1 = 8'd3;
    fill_r = 8'h01; fill_g = 8'h02; fill_b = 8'h03;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("abort_px%0d", i), wr_state(),
            wr_exp(1'b1, 8'(i % 4), 8'(i / 4), 8'h01, 8'h02, 8'h03, 1'b0, 1'b1));
    end
    fill_abort = 1'b1; fill_start = 1'b1;
    tick();
    fill_abort = 1'b0; fill_start = 1'b0;
    check("abort_cycle", wr_state(), wr_exp(1'b0, 8'd0, 8'd1, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("abort_quiet%0d", i), wr_state(),
            wr_exp(1'b0, 8'd0, 8'd1, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0));
    end
    // Start and abort together in IDLE: start must be ignored.
    fill_abort = 1'b1; fill_start = 1'b1;
    tick();
    fill_abort = 1'b0; fill_start = 1'b0;
    check("idle_abort_start", 64'(fill_busy), 64'd0);
    tick();
    check("idle_abort_nowrite", 64'(write_en), 64'd0);

    // Reset mid-fill with a pending host beat.
    fill_x0 = 8'd0; fill_y0 = 8'd0; fill_x1 = 8'd7; fill_y1 = 8'd7;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    tick();
    tick();
    iRST_N = 1'b0; host_valid = 1'b1;
    #1;
    check("midrst_host_ready", 64'(host_ready), 64'd0);
    tick();
    check("midrst_outputs", wr_state(), 64'd0);
    iRST_N = 1'b1; host_valid = 1'b0;
    tick();
    check("midrst_idle", wr_state(), 64'd0);

    // Contention: host streams (100+k,7) during a 1x4 fill.
    k = 0;
    host_valid = 1'b1; host_x = 8'd100; host_y = 8'd7;
    host_r = 8'd0; host_g = 8'h22; host_b = 8'h33;
    fill_x0 = 8'd0; fill_y0 = 8'd0; fill_x1 = 8'd3; fill_y1 = 8'd0;
    fill_r = 8'hAA; fill_g = 8'hBB; fill_b = 8'hCC;
    fill_start = 1'b1;
    #1;
    check("cont_ready0", 64'(host_ready), 64'd1);
    tick();
    fill_start = 1'b0;
    k = 1; host_x = 8'd101; host_r = 8'd1;
    check("cont_h0", wr_state(), wr_exp(1'b1, 8'd100, 8'd7, 8'd0, 8'h22, 8'h33, 1'b0, 1'b1));
    for (int j = 0; j < 8; j++) begin
      hr = host_ready;
      check($sformatf("cont_ready_%0d", j), 64'(hr), 64'(j % 2));
      tick();
      if (hr) begin
        k++;
        host_x = 8'(100 + k);
        host_r = 8'(k);
      end
      if (j % 2 == 1)
        check($sformatf("cont_h_%0d", j), wr_state(),
              wr_exp(1'b1, 8'(100 + (j + 1) / 2), 8'd7, 8'((j + 1) / 2), 8'h22, 8'h33,
                     1'b0, 1'(j < 6)));
      else
        check($sformatf("cont_f_%0d", j), wr_state(),
              wr_exp(1'b1, 8'(j / 2), 8'd0, 8'hAA, 8'hBB, 8'hCC, 1'(j == 6), 1'(j < 6)));
    end
    host_valid = 1'b0;
    tick();
    check("cont_end", 64'(write_en), 64'd0);

    run_fill("full", 8'd0, 8'd0, 8'd255, 8'd255, 8'h55, 8'h66, 8'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
